// File: rtl/canvas_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | canvas_arbiter: port-A arbiter for the canvas RAM (clear > rec > mouse)|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module canvas_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_req,
    input  logic       rec_req,
    input  logic [9:0] rec_addr,
    input  logic       mou_we,
    input  logic [9:0] mou_addr,
    input  logic       mou_data,
    input  logic       mem_spo,
    output logic [9:0] mem_a,
    output logic       mem_d,
    output logic       mem_we,
    output logic       rec_gnt,
    output logic       rec_valid,
    output logic       rec_data,
    output logic       mou_gnt,
    output logic       clr_busy,
    output logic       clr_done,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REC   = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [9:0] C_LAST_ADDR = 10'd1023;
    localparam logic [7:0] C_DROP_MAX  = 8'd255;

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic       clr_pend_q, clr_pend_d;
    logic       rec_valid_q, rec_valid_d;
    logic       rec_data_q, rec_data_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_pend_d = clr_pend_q;
        mem_a      = mou_addr;
        mem_d      = 1'b0;
        mem_we     = 1'b0;
        rec_gnt    = 1'b0;
        mou_gnt    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // rst gating keeps the mouse grant low while reset is held
                mou_gnt = mou_we & ~rec_req & ~clr_req & ~clr_pend_q & rst;
                if (mou_gnt) begin
                    mem_d  = mou_data;
                    mem_we = 1'b1;
                end
                if (clr_req || clr_pend_q) begin
                    state_d    = S_CLEAR;
                    cnt_d      = 10'd0;
                    clr_pend_d = 1'b0;
                end else if (rec_req) begin
                    state_d = S_REC;
                end
            end
            S_REC: begin
                rec_gnt = 1'b1;
                mem_a   = rec_addr;
                if (clr_req) begin
                    clr_pend_d = 1'b1;
                end
                if (!rec_req) begin
                    if (clr_pend_q) begin
                        state_d    = S_CLEAR;
                        cnt_d      = 10'd0;
                        clr_pend_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                mem_a  = cnt_q;
                mem_we = 1'b1;
                cnt_d  = cnt_q + 10'd1;
                if (cnt_q == C_LAST_ADDR) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rec_valid_d = (state_q == S_REC);
        rec_data_d  = rec_valid_d ? mem_spo : rec_data_q;
        drop_cnt_d  = drop_cnt_q;
        if (mou_we && !mou_gnt && (drop_cnt_q != C_DROP_MAX)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 10'd0;
            clr_pend_q  <= 1'b0;
            rec_valid_q <= 1'b0;
            rec_data_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_pend_q  <= clr_pend_d;
            rec_valid_q <= rec_valid_d;
            rec_data_q  <= rec_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign rec_valid = rec_valid_q;
    assign rec_data  = rec_data_q;
    assign drop_cnt  = drop_cnt_q;
    assign clr_busy  = (state_q == S_CLEAR);
    assign clr_done  = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_canvas_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_canvas_arbiter: directed self-checking bench with a canvas model  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_canvas_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_req, rec_req, mou_we, mou_data;
    logic [9:0] rec_addr, mou_addr;
    logic       mem_spo;
    logic [9:0] mem_a;
    logic       mem_d, mem_we, rec_gnt, rec_valid, rec_data, mou_gnt;
    logic       clr_busy, clr_done;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic mem [0:1023] = '{default: 1'b1};

    canvas_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .rec_req  (rec_req),
        .rec_addr (rec_addr),
        .mou_we   (mou_we),
        .mou_addr (mou_addr),
        .mou_data (mou_data),
        .mem_spo  (mem_spo),
        .mem_a    (mem_a),
        .mem_d    (mem_d),
        .mem_we   (mem_we),
        .rec_gnt  (rec_gnt),
        .rec_valid(rec_valid),
        .rec_data (rec_data),
        .mou_gnt  (mou_gnt),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Canvas RAM: asynchronous read, synchronous write
    assign mem_spo = mem[mem_a];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_d;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (clr_done !== 1'b1 && n < 1100) begin
            step();
            n++;
        end
        check_val(tag, {31'd0, clr_done}, 32'd1);
    endtask

    logic [3:0] pat = 4'b1101;
    int bad_a, bad_d, bad_we, bad_busy, ones;

    initial begin
        rst = 1'b0; clr_req = 1'b0; rec_req = 1'b0; rec_addr = 10'd0;
        mou_we = 1'b1; mou_addr = 10'd5; mou_data = 1'b1;
        #3;
        check_val("rst_mou_gnt",  {31'd0, mou_gnt},   32'd0);
        check_val("rst_mem_we",   {31'd0, mem_we},    32'd0);
        check_val("rst_rec_gnt",  {31'd0, rec_gnt},   32'd0);
        check_val("rst_clr_busy", {31'd0, clr_busy},  32'd0);
        check_val("rst_clr_done", {31'd0, clr_done},  32'd0);
        check_val("rst_rec_valid",{31'd0, rec_valid}, 32'd0);
        check_val("rst_drop",     {24'd0, drop_cnt},  32'd0);
        step();
        rst = 1'b1; mou_we = 1'b0;

        // Single mouse write in IDLE
        mou_we = 1'b1; mou_addr = 10'h155; mou_data = 1'b1;
        #1;
        check_val("mou_gnt",  {31'd0, mou_gnt}, 32'd1);
        check_val("mou_we",   {31'd0, mem_we},  32'd1);
        check_val("mou_addr", {22'd0, mem_a},   32'h155);
        check_val("mou_data", {31'd0, mem_d},   32'd1);
        step();
        mou_we = 1'b0;
        check_val("mou_drop0", {24'd0, drop_cnt}, 32'd0);

        // Preload addresses 0..3 with a known pattern
        for (int i = 0; i < 4; i++) begin
            mou_we = 1'b1; mou_addr = 10'(i); mou_data = pat[i];
            #1;
            check_val("preload_gnt", {31'd0, mou_gnt}, 32'd1);
            step();
        end
        mou_we = 1'b0;

        // Recognizer burst with the mouse writing throughout
        mou_we = 1'b1; rec_req = 1'b1; rec_addr = 10'd0;
        #1;
        check_val("burst_c1_rec_gnt", {31'd0, rec_gnt}, 32'd0);
        check_val("burst_c1_mou_gnt", {31'd0, mou_gnt}, 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            rec_addr = 10'(k);
            #1;
            check_val("burst_rec_gnt", {31'd0, rec_gnt}, 32'd1);
            check_val("burst_mou_gnt", {31'd0, mou_gnt}, 32'd0);
            check_val("burst_mem_we",  {31'd0, mem_we},  32'd0);
            check_val("burst_mem_a",   {22'd0, mem_a},   32'(k));
            if (k > 0) begin
                check_val("burst_valid", {31'd0, rec_valid}, 32'd1);
                check_val("burst_data",  {31'd0, rec_data},  {31'd0, pat[k-1]});
            end
            step();
        end
        rec_req = 1'b0; mou_we = 1'b0;
        #1;
        check_val("burst_last_valid", {31'd0, rec_valid}, 32'd1);
        check_val("burst_last_data",  {31'd0, rec_data},  {31'd0, pat[3]});
        check_val("burst_drop",       {24'd0, drop_cnt},  32'd5);
        step();
        check_val("burst_exit_gnt", {31'd0, rec_gnt}, 32'd0);
        step();

        // Full clear sweep; a second clr_req at cnt=500 must be ignored
        clr_req = 1'b1;
        step();
        bad_a = 0; bad_d = 0; bad_we = 0; bad_busy = 0;
        for (int i = 0; i < 1024; i++) begin
            clr_req = (i == 500);
            #1;
            if (mem_a !== 10'(i)) bad_a++;
            if (mem_d !== 1'b0) bad_d++;
            if (mem_we !== 1'b1) bad_we++;
            if (clr_busy !== 1'b1 || rec_gnt !== 1'b0 || mou_gnt !== 1'b0) bad_busy++;
            step();
        end
        clr_req = 1'b0;
        check_val("sweep_addr", 32'(bad_a),    32'd0);
        check_val("sweep_data", 32'(bad_d),    32'd0);
        check_val("sweep_we",   32'(bad_we),   32'd0);
        check_val("sweep_busy", 32'(bad_busy), 32'd0);
        check_val("done_pulse", {31'd0, clr_done}, 32'd1);
        check_val("done_busy",  {31'd0, clr_busy}, 32'd0);
        check_val("done_we",    {31'd0, mem_we},   32'd0);
        step();
        check_val("after_done", {31'd0, clr_done}, 32'd0);
        check_val("no_resweep", {31'd0, clr_busy}, 32'd0);
        ones = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== 1'b0) ones++;
        check_val("canvas_zero", 32'(ones), 32'd0);

        // clr_req during a burst is deferred until rec_req drops
        rec_req = 1'b1;
        step();
        clr_req = 1'b1;
        #1;
        check_val("defer_gnt", {31'd0, rec_gnt}, 32'd1);
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_val("defer_no_we",  {31'd0, mem_we},   32'd0);
            check_val("defer_nobusy", {31'd0, clr_busy}, 32'd0);
            step();
        end
        rec_req = 1'b0;
        #1;
        check_val("defer_exit_gnt", {31'd0, rec_gnt}, 32'd1);
        check_val("defer_exit_we",  {31'd0, mem_we},  32'd0);
        step();
        check_val("defer_clear", {31'd0, clr_busy}, 32'd1);
        check_val("defer_addr0", {22'd0, mem_a},    32'd0);
        wait_done("defer_done");
        step();

        // Simultaneous clr_req and rec_req in IDLE: clear wins
        clr_req = 1'b1; rec_req = 1'b1;
        #1;
        check_val("simul_rec_gnt0", {31'd0, rec_gnt}, 32'd0);
        step();
        clr_req = 1'b0;
        check_val("simul_busy",    {31'd0, clr_busy}, 32'd1);
        check_val("simul_rec_gnt", {31'd0, rec_gnt},  32'd0);
        wait_done("simul_done");
        check_val("simul_done_gnt", {31'd0, rec_gnt}, 32'd0);
        step();
        check_val("simul_idle_gnt", {31'd0, rec_gnt}, 32'd0);
        step();
        check_val("simul_rec_entry", {31'd0, rec_gnt}, 32'd1);
        rec_req = 1'b0;
        step();
        step();

        // Asynchronous reset mid-sweep at cnt=300
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (300) step();
        check_val("sweep_cnt300", {22'd0, mem_a}, 32'd300);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_busy", {31'd0, clr_busy}, 32'd0);
        check_val("async_we",   {31'd0, mem_we},   32'd0);
        check_val("async_drop", {24'd0, drop_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_val("post_rst_idle", {31'd0, clr_busy}, 32'd0);

        // Drop counter saturation
        mou_we = 1'b1; rec_req = 1'b1;
        repeat (254) step();
        check_val("drop_254", {24'd0, drop_cnt}, 32'd254);
        repeat (46) step();
        check_val("drop_sat", {24'd0, drop_cnt}, 32'd255);
        mou_we = 1'b0; rec_req = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
